bp_controller: RTL and testbench

BP_CONTROLLER -- requirements
Module: bp_controller

---
 rtl/bp_controller.sv | 145 ++++++++++++++
 tb/tb_bp_controller.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_controller.sv
// bp_controller: 2-bit BHT direction predictor with static fallback
// and a one-entry-per-cycle invalidation sweep.
`ifndef TAKEN
`define TAKEN 1
`endif
`ifndef BTFNT
`define BTFNT 2
`endif

module static_predictor #(
  parameter int MODE = `BTFNT
) (
  input  logic [31:0] pc,
  input  logic [31:0] pc_next,
  output logic        taken
);
  always_comb begin
    taken = 1'b0;
    if (MODE == `TAKEN) begin
      taken = 1'b1;
    end else if (MODE == `BTFNT) begin
      taken = pc_next < pc;
    end
  end
endmodule

module bp_controller #(
  parameter int FALLBACK_MODE = `BTFNT,
  parameter int INDEX_WIDTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lookup_valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_next_i,
  input  logic        update_valid_i,
  input  logic [31:0] update_pc_i,
  input  logic        update_taken_i,
  input  logic        flush_i,
  output logic        pred_valid_o,
  output logic        pred_taken_o,
  output logic        pred_src_o,
  output logic        busy_o,
  output logic [15:0] lookup_cnt_o,
  output logic [15:0] hit_cnt_o
);
  localparam int N = 2**INDEX_WIDTH;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [INDEX_WIDTH-1:0] sweep_q;
  logic [N-1:0]           valid_q;
  logic [1:0]             ctr_q [N];

  logic [INDEX_WIDTH-1:0] lidx;
  logic [INDEX_WIDTH-1:0] uidx;
  logic                   hit;
  logic                   sweep_last;
  logic                   static_taken;
  logic [1:0]             ucur;
  logic [1:0]             ctr_nxt;

  assign lidx       = pc_i[INDEX_WIDTH+1:2];
  assign uidx       = update_pc_i[INDEX_WIDTH+1:2];
  assign hit        = (state_q == IDLE) && valid_q[lidx];
  assign sweep_last = sweep_q == INDEX_WIDTH'(N-1);
  assign ucur       = ctr_q[uidx];

  static_predictor #(
    .MODE(FALLBACK_MODE)
  ) u_static (
    .pc     (pc_i),
    .pc_next(pc_next_i),
    .taken  (static_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (flush_i) state_d = FLUSH;
      FLUSH:   if (sweep_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == FLUSH);
  end

  // A fresh entry starts weakly biased toward its first outcome.
  always_comb begin
    ctr_nxt = ucur;
    if (!valid_q[uidx]) begin
      ctr_nxt = update_taken_i ? 2'b10 : 2'b01;
    end else if (update_taken_i) begin
      if (ucur != 2'b11) ctr_nxt = ucur + 2'b01;
    end else begin
      if (ucur != 2'b00) ctr_nxt = ucur - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      sweep_q <= '0;
      for (int i = 0; i < N; i++) begin
        ctr_q[i] <= 2'b00;
      end
    end else if (state_q == FLUSH) begin
      valid_q[sweep_q] <= 1'b0;
      sweep_q          <= sweep_q + INDEX_WIDTH'(1);
    end else if (update_valid_i) begin
      valid_q[uidx] <= 1'b1;
      ctr_q[uidx]   <= ctr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_o <= 1'b0;
      pred_taken_o <= 1'b0;
      pred_src_o   <= 1'b0;
      lookup_cnt_o <= '0;
      hit_cnt_o    <= '0;
    end else begin
      pred_valid_o <= lookup_valid_i;
      if (lookup_valid_i) begin
        pred_taken_o <= hit ? ctr_q[lidx][1] : static_taken;
        pred_src_o   <= hit;
        lookup_cnt_o <= lookup_cnt_o + 16'd1;
        if (hit) hit_cnt_o <= hit_cnt_o + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_bp_controller.sv
// tb_bp_controller: random and directed stimulus against a
// table-of-counters model, three fallback-mode builds in parallel.
`ifndef TAKEN
`define TAKEN 1
`endif
`ifndef BTFNT
`define BTFNT 2
`endif

module tb_bp_controller;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lookup_valid_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] pc_next_i = '0;
  logic        update_valid_i = 1'b0;
  logic [31:0] update_pc_i = '0;
  logic        update_taken_i = 1'b0;
  logic        flush_i = 1'b0;

  logic        pv, pt, ps, bz;
  logic [15:0] lc, hc;
  logic        pv_t, pt_t, ps_t, bz_t;
  logic [15:0] lc_t, hc_t;
  logic        pv_n, pt_n, ps_n, bz_n;
  logic [15:0] lc_n, hc_n;

  bp_controller #(.FALLBACK_MODE(`BTFNT), .INDEX_WIDTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid_i(lookup_valid_i), .pc_i(pc_i), .pc_next_i(pc_next_i),
    .update_valid_i(update_valid_i), .update_pc_i(update_pc_i),
    .update_taken_i(update_taken_i), .flush_i(flush_i),
    .pred_valid_o(pv), .pred_taken_o(pt), .pred_src_o(ps),
    .busy_o(bz), .lookup_cnt_o(lc), .hit_cnt_o(hc)
  );

  bp_controller #(.FALLBACK_MODE(`TAKEN), .INDEX_WIDTH(4)) u_dut_t (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid_i(lookup_valid_i), .pc_i(pc_i), .pc_next_i(pc_next_i),
    .update_valid_i(update_valid_i), .update_pc_i(update_pc_i),
    .update_taken_i(update_taken_i), .flush_i(flush_i),
    .pred_valid_o(pv_t), .pred_taken_o(pt_t), .pred_src_o(ps_t),
    .busy_o(bz_t), .lookup_cnt_o(lc_t), .hit_cnt_o(hc_t)
  );

  bp_controller #(.FALLBACK_MODE(0), .INDEX_WIDTH(4)) u_dut_n (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid_i(lookup_valid_i), .pc_i(pc_i), .pc_next_i(pc_next_i),
    .update_valid_i(update_valid_i), .update_pc_i(update_pc_i),
    .update_taken_i(update_taken_i), .flush_i(flush_i),
    .pred_valid_o(pv_n), .pred_taken_o(pt_n), .pred_src_o(ps_n),
    .busy_o(bz_n), .lookup_cnt_o(lc_n), .hit_cnt_o(hc_n)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  bit m_val [N];
  int m_ctr [N];
  int m_left;
  int m_pos;
  bit m_pv, m_pt, m_ps, m_pt_t, m_pt_n;
  int m_lc, m_hc;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_val[i] = 1'b0;
      m_ctr[i] = 0;
    end
    m_left = 0;
    m_pos  = 0;
    m_pv = 0; m_pt = 0; m_ps = 0; m_pt_t = 0; m_pt_n = 0;
    m_lc = 0; m_hc = 0;
  endfunction

  function automatic logic [37:0] obs();
    return {pv, pt, ps, bz, lc, hc, pt_t, pt_n};
  endfunction

  function automatic logic [37:0] expv();
    return {m_pv, m_pt, m_ps, m_left != 0, 16'(m_lc), 16'(m_hc),
            m_pt_t, m_pt_n};
  endfunction

  task automatic drive(input bit lv, input logic [31:0] pc,
                       input logic [31:0] pn, input bit uv,
                       input logic [31:0] upc, input bit ut,
                       input bit fl);
    int  li, ui;
    bit  hit, bht;
    lookup_valid_i = lv;
    pc_i           = pc;
    pc_next_i      = pn;
    update_valid_i = uv;
    update_pc_i    = upc;
    update_taken_i = ut;
    flush_i        = fl;
    li  = int'((pc >> 2) % N);
    ui  = int'((upc >> 2) % N);
    hit = (m_left == 0) && m_val[li];
    bht = m_ctr[li] >= 2;
    m_pv = lv;
    if (lv) begin
      m_ps   = hit;
      m_pt   = hit ? bht : (pn < pc);
      m_pt_t = hit ? bht : 1'b1;
      m_pt_n = hit ? bht : 1'b0;
      m_lc   = (m_lc + 1) % 65536;
      if (hit) m_hc = (m_hc + 1) % 65536;
    end
    if (m_left != 0) begin
      m_val[m_pos] = 1'b0;
      m_pos  = (m_pos + 1) % N;
      m_left = m_left - 1;
    end else begin
      if (uv) begin
        if (!m_val[ui]) m_ctr[ui] = ut ? 2 : 1;
        else if (ut) m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
        else m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
        m_val[ui] = 1'b1;
      end
      if (fl) m_left = N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    n_vec++;
    if (obs() !== 38'h0) begin
      n_err++;
      $display("FAIL reset_hold got %h exp %h", obs(), 38'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (obs() !== expv()) begin
      n_err++;
      $display("FAIL reset_release got %h exp %h", obs(), expv());
    end
  endtask

  task automatic test_btfnt_miss();
    drive(1, 32'h100, 32'h0F0, 0, 0, 0, 0);
    n_vec++;
    if ({pv, pt, ps, lc, hc, pt_t, pt_n} !== {3'b110, 16'd1, 16'd0, 2'b10}) begin
      n_err++;
      $display("FAIL btfnt_miss got v%b t%b s%b lc%0d hc%0d", pv, pt, ps, lc, hc);
    end
    idle();
    n_vec++;
    if (obs() !== expv()) begin
      n_err++;
      $display("FAIL btfnt_hold got %h exp %h", obs(), expv());
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 32'h104, 1, 0);
    drive(1, 32'h104, 32'h200, 0, 0, 0, 0);
    n_vec++;
    if ({pv, pt, ps} !== 3'b111 || obs() !== expv()) begin
      n_err++;
      $display("FAIL sat_up got %h exp %h", obs(), expv());
    end
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 32'h104, 0, 0);
    drive(1, 32'h104, 32'h0, 0, 0, 0, 0);
    n_vec++;
    if ({pv, pt, ps} !== 3'b101 || obs() !== expv()) begin
      n_err++;
      $display("FAIL sat_down got %h exp %h", obs(), expv());
    end
  endtask

  task automatic test_rbw();
    drive(1, 32'h108, 32'h200, 1, 32'h108, 1, 0);
    n_vec++;
    if ({pv, pt, ps} !== 3'b100 || obs() !== expv()) begin
      n_err++;
      $display("FAIL rbw_same got %h exp %h", obs(), expv());
    end
    drive(1, 32'h108, 32'h200, 0, 0, 0, 0);
    n_vec++;
    if ({pv, pt, ps} !== 3'b111 || obs() !== expv()) begin
      n_err++;
      $display("FAIL rbw_next got %h exp %h", obs(), expv());
    end
  endtask

  task automatic test_random();
    logic [31:0] pc, pn, upc;
    for (int i = 0; i < 400; i++) begin
      pc  = 32'h1000 + 32'($urandom_range(0, 31) * 4);
      upc = 32'h1000 + 32'($urandom_range(0, 31) * 4);
      pn  = $urandom;
      drive(1'($urandom), pc, pn, 1'($urandom), upc, 1'($urandom),
            $urandom_range(0, 60) == 0);
      n_vec++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL random[%0d] got %h exp %h", i, obs(), expv());
      end
    end
    while (m_left != 0) idle();
  endtask

  task automatic test_flush();
    int busy_cycles;
    for (int i = 0; i < N; i++) begin
      drive(0, 0, 0, 1, 32'h2000 + 32'(i * 4), 1'($urandom), 0);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    busy_cycles = 0;
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL flush_sweep[%0d] got %h exp %h", i, obs(), expv());
      end
      if (bz === 1'b1) busy_cycles++;
      drive(1'($urandom), 32'h2000 + 32'($urandom_range(0, 15) * 4),
            $urandom, 1'($urandom),
            32'h2000 + 32'($urandom_range(0, 15) * 4), 1'($urandom),
            1'($urandom));
    end
    n_vec++;
    if (busy_cycles != N || bz !== 1'b0) begin
      n_err++;
      $display("FAIL flush_len got %0d busy=%b exp %0d busy=0", busy_cycles, bz, N);
    end
    for (int i = 0; i < N; i++) begin
      drive(1, 32'h2000 + 32'(i * 4), 32'h0, 0, 0, 0, 0);
      n_vec++;
      if (ps !== 1'b0 || obs() !== expv()) begin
        n_err++;
        $display("FAIL flush_after[%0d] got %h exp %h", i, obs(), expv());
      end
    end
  endtask

  task automatic test_wrap();
    int lc0;
    lc0 = m_lc;
    for (int i = 0; i < 65536; i++) begin
      drive(1, 32'h3000 + 32'($urandom_range(0, 15) * 4), $urandom,
            1'($urandom), 32'h3000 + 32'($urandom_range(0, 15) * 4),
            1'($urandom), 0);
      n_vec++;
      if (obs() !== expv()) begin
        n_err++;
        $display("FAIL wrap[%0d] got %h exp %h", i, obs(), expv());
      end
    end
    n_vec++;
    if (lc !== 16'(lc0)) begin
      n_err++;
      $display("FAIL wrap_cnt got %0d exp %0d", lc, lc0);
    end
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 0; i < N; i++) drive(0, 0, 0, 1, 32'(i * 4), 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) idle();
    n_vec++;
    if (bz !== 1'b1) begin
      n_err++;
      $display("FAIL midsweep_busy got %b exp 1", bz);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (obs() !== 38'h0) begin
      n_err++;
      $display("FAIL midsweep_rst got %h exp %h", obs(), 38'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      drive(1, 32'(i * 4), 32'hFFFF_FFFF, 0, 0, 0, 0);
      n_vec++;
      if (ps !== 1'b0 || bz !== 1'b0 || obs() !== expv()) begin
        n_err++;
        $display("FAIL midsweep_after[%0d] got %h exp %h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_btfnt_miss();
    test_saturate();
    test_rbw();
    test_random();
    test_flush();
    test_wrap();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
